// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        RESTART
    } state_t;

    localparam int OFFSET_W  = 5;
    localparam int WORD_W    = 3;
    localparam int LINE_BITS = 256;
    localparam int WORDS     = LINE_BITS / 32;

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines);
        return 32 - OFFSET_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Valid/dirty/tag/data storage: combinational read, one synchronous write port
// that either refills a whole line or stores individual words.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int IDX_W = 5,
    parameter int TAG_W = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [WORDS-1:0]     word_we,
    input  logic [31:0]          word_data,
    input  logic                 line_we,
    input  logic [LINE_BITS-1:0] line_data,
    input  logic [TAG_W-1:0]     line_tag
);

    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;
    logic [TAG_W-1:0]     tags  [LINES];
    logic [LINE_BITS-1:0] lines [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_line  = lines[rd_idx];

    // Only the status bits need reset; tag and data are qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (line_we) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= 1'b0;
        end else if (|word_we) begin
            dirty[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            lines[wr_idx] <= line_data;
            tags[wr_idx]  <= line_tag;
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                if (word_we[w]) begin
                    lines[wr_idx][32*w +: 32] <= word_data;
                end
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Define DCACHE_STATS_EN to add hit/miss counter outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    localparam int IDX_W = index_w(LINES);
    localparam int TAG_W = tag_w(LINES);

    state_t               state;
    logic [WORD_W-1:0]    word_sel;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [IDX_W-1:0]     miss_idx;
    logic [TAG_W-1:0]     miss_tag;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic [IDX_W-1:0]     wr_idx;
    logic [WORDS-1:0]     word_we;
    logic                 line_we;
    logic                 hit;
    logic [1:0]           unused_addr_bits;

    assign word_sel         = cpu_addr_i[OFFSET_W-1:2];
    assign idx              = cpu_addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
    assign tag              = cpu_addr_i[31:OFFSET_W+IDX_W];
    assign unused_addr_bits = cpu_addr_i[1:0];

    assign hit         = cpu_req_i && rd_valid && (rd_tag == tag);
    assign cpu_stall_o = (state != IDLE) || (cpu_req_i && !hit);
    assign cpu_rdata_o = (state == IDLE && hit && !cpu_we_i) ? rd_line[32*word_sel +: 32] : '0;

    // The refill targets the latched miss index, so a dropped request cannot redirect it.
    assign line_we = (state == ALLOCATE) && mem_ack_i;
    assign word_we = (state == IDLE && hit && cpu_we_i) ?
                     ({{(WORDS-1){1'b0}}, 1'b1} << word_sel) : '0;
    assign wr_idx  = (state == ALLOCATE) ? miss_idx : idx;

    dcache_sram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_sram (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .rd_idx    (idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_idx    (wr_idx),
        .word_we   (word_we),
        .word_data (cpu_wdata_i),
        .line_we   (line_we),
        .line_data (mem_data_i),
        .line_tag  (miss_tag)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            miss_idx     <= '0;
            miss_tag     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_i && !hit) begin
                        miss_idx     <= idx;
                        miss_tag     <= tag;
                        mem_enable_o <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state       <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {rd_tag, idx, {OFFSET_W{1'b0}}};
                            mem_data_o  <= rd_line;
                        end else begin
                            state       <= ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {tag, idx, {OFFSET_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state       <= ALLOCATE;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {miss_tag, miss_idx, {OFFSET_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state        <= RESTART;
                        mem_enable_o <= 1'b0;
                    end
                end
                RESTART: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // The post-refill replay is a genuine IDLE hit, so every miss also counts one hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state == IDLE) begin
            if (hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end else if (cpu_req_i) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a latency-configurable line memory model.
// Counter checks are compiled in only when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    int vectors;
    int miscompares;
    int wb_count;
    int rd_count;
    logic [31:0]  last_wb_addr;
    logic [255:0] last_wb_data;
    logic [31:0]  last_rd_addr;
    logic [255:0] mem_lines [logic [31:0]];

    dcache_ctrl #(.LINES(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Untouched memory: word w of line A holds 0xA5000000 + A + 4w.
    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (mem_lines.exists(a)) return mem_lines[a];
        for (int w = 0; w < 8; w++) l[32*w +: 32] = 32'hA500_0000 + a + 32'(4 * w);
        return l;
    endfunction

    // One CPU access; serves the memory port with latency lat and counts stalled cycles.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int lat, input int drop_at,
                             output int stalls, output logic [31:0] rdata);
        int  req_cnt;
        int  cyc;
        bit  done;
        stalls  = 0;
        req_cnt = 0;
        cyc     = 0;
        done    = 0;
        rdata   = '0;
        @(negedge clk_i);
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        while (!done && cyc < 200) begin
            #1;
            cyc++;
            if (drop_at != 0 && cyc == drop_at) begin
                cpu_req_i = 1'b0;
                #1;
            end
            mem_ack_i = 1'b0;
            if (mem_enable_o) begin
                req_cnt++;
                if (req_cnt == lat) begin
                    mem_ack_i = 1'b1;
                    req_cnt   = 0;
                    if (mem_write_o) begin
                        wb_count++;
                        last_wb_addr = mem_addr_o;
                        last_wb_data = mem_data_o;
                        mem_lines[mem_addr_o] = mem_data_o;
                    end else begin
                        rd_count++;
                        last_rd_addr = mem_addr_o;
                        mem_data_i   = line_of(mem_addr_o);
                    end
                end
            end else begin
                req_cnt = 0;
            end
            if (cpu_stall_o) stalls++;
            else begin
                done  = 1;
                rdata = cpu_rdata_o;
            end
            if (!done) @(negedge clk_i);
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL access_timeout addr=%h: stall never released within 200 cycles", addr);
        end
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i       = 1'b0;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        mem_data_i  = '0;
        mem_ack_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        vectors++;
        if (cpu_stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b expected 0", cpu_stall_o); end
        vectors++;
        if (cpu_rdata_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", cpu_rdata_o); end
        vectors++;
        if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mem_ctl: got en=%b we=%b expected 0/0", mem_enable_o, mem_write_o);
        end
        vectors++;
        if (mem_addr_o !== 32'h0 || mem_data_o !== 256'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mem_bus: got addr=%h data=%h expected zeros", mem_addr_o, mem_data_o);
        end
`ifdef DCACHE_STATS_EN
        vectors++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_counters: got hit=%0d miss=%0d expected 0/0", hit_cnt_o, miss_cnt_o);
        end
`endif
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        vectors++;
        if (cpu_stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_stall: got %b expected 0", cpu_stall_o); end
    endtask

    task automatic test_clean_miss();
        int          stalls;
        logic [31:0] rdata;
        do_access(1'b0, 32'h0000_0040, 32'h0, 4, 0, stalls, rdata);
        vectors++;
        if (stalls !== 6) begin miscompares++; $display("[TB] FAIL clean_miss_stall: got %0d expected 6", stalls); end
        vectors++;
        if (rd_count !== 1 || last_rd_addr !== 32'h40) begin
            miscompares++;
            $display("[TB] FAIL clean_miss_read: got count=%0d addr=%h expected 1/00000040", rd_count, last_rd_addr);
        end
        vectors++;
        if (wb_count !== 0) begin miscompares++; $display("[TB] FAIL clean_miss_no_wb: got %0d expected 0", wb_count); end
        vectors++;
        if (rdata !== 32'hA500_0040) begin miscompares++; $display("[TB] FAIL clean_miss_rdata: got %h expected a5000040", rdata); end
        do_access(1'b0, 32'h0000_0040, 32'h0, 4, 0, stalls, rdata);
        vectors++;
        if (stalls !== 0 || rdata !== 32'hA500_0040) begin
            miscompares++;
            $display("[TB] FAIL reload_hit: got stall=%0d data=%h expected 0/a5000040", stalls, rdata);
        end
    endtask

    task automatic test_hit_store();
        int          stalls;
        logic [31:0] rdata;
        do_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 4, 0, stalls, rdata);
        vectors++;
        if (stalls !== 0) begin miscompares++; $display("[TB] FAIL store_hit_stall: got %0d expected 0", stalls); end
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL store_rdata_zero: got %h expected 0", rdata); end
        do_access(1'b0, 32'h0000_0044, 32'h0, 4, 0, stalls, rdata);
        vectors++;
        if (stalls !== 0 || rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("[TB] FAIL store_readback: got stall=%0d data=%h expected 0/deadbeef", stalls, rdata);
        end
`ifdef DCACHE_STATS_EN
        vectors++;
        if (hit_cnt_o !== 32'd4 || miss_cnt_o !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL counters_after_store: got hit=%0d miss=%0d expected 4/1", hit_cnt_o, miss_cnt_o);
        end
`endif
    endtask

    task automatic test_dirty_miss();
        int          stalls;
        logic [31:0] rdata;
        do_access(1'b0, 32'h0000_0444, 32'h0, 4, 0, stalls, rdata);
        vectors++;
        if (stalls !== 10) begin miscompares++; $display("[TB] FAIL dirty_miss_stall: got %0d expected 10", stalls); end
        vectors++;
        if (wb_count !== 1 || last_wb_addr !== 32'h40) begin
            miscompares++;
            $display("[TB] FAIL wb_addr: got count=%0d addr=%h expected 1/00000040", wb_count, last_wb_addr);
        end
        vectors++;
        if (last_wb_data[63:32] !== 32'hDEAD_BEEF || last_wb_data[31:0] !== 32'hA500_0040
            || last_wb_data[255:224] !== 32'hA500_005C) begin
            miscompares++;
            $display("[TB] FAIL wb_data: got w1=%h w0=%h w7=%h expected deadbeef/a5000040/a500005c",
                     last_wb_data[63:32], last_wb_data[31:0], last_wb_data[255:224]);
        end
        vectors++;
        if (rd_count !== 2 || last_rd_addr !== 32'h440) begin
            miscompares++;
            $display("[TB] FAIL dirty_refill_addr: got count=%0d addr=%h expected 2/00000440", rd_count, last_rd_addr);
        end
        vectors++;
        if (rdata !== 32'hA500_0444) begin miscompares++; $display("[TB] FAIL dirty_miss_rdata: got %h expected a5000444", rdata); end
`ifdef DCACHE_STATS_EN
        vectors++;
        if (hit_cnt_o !== 32'd5 || miss_cnt_o !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL counters_after_dirty: got hit=%0d miss=%0d expected 5/2", hit_cnt_o, miss_cnt_o);
        end
`endif
    endtask

    task automatic test_spurious_ack();
        int          stalls;
        logic [31:0] rdata;
        @(negedge clk_i);
        mem_ack_i = 1'b1;
        #1;
        vectors++;
        if (cpu_stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL spurious_ack_during: got stall=%b en=%b expected 0/0", cpu_stall_o, mem_enable_o);
        end
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        vectors++;
        if (mem_enable_o !== 1'b0) begin miscompares++; $display("[TB] FAIL spurious_ack_after: got en=%b expected 0", mem_enable_o); end
        do_access(1'b0, 32'h0000_0444, 32'h0, 4, 0, stalls, rdata);
        vectors++;
        if (stalls !== 0 || rdata !== 32'hA500_0444) begin
            miscompares++;
            $display("[TB] FAIL post_ack_hit: got stall=%0d data=%h expected 0/a5000444", stalls, rdata);
        end
    endtask

    task automatic test_req_drop();
        int          stalls;
        logic [31:0] rdata;
        do_access(1'b0, 32'h0000_0080, 32'h0, 4, 2, stalls, rdata);
        vectors++;
        if (stalls !== 6 || rd_count !== 3 || last_rd_addr !== 32'h80) begin
            miscompares++;
            $display("[TB] FAIL req_drop_refill: got stall=%0d reads=%0d addr=%h expected 6/3/00000080",
                     stalls, rd_count, last_rd_addr);
        end
        do_access(1'b0, 32'h0000_0080, 32'h0, 4, 0, stalls, rdata);
        vectors++;
        if (stalls !== 0 || rdata !== 32'hA500_0080) begin
            miscompares++;
            $display("[TB] FAIL req_drop_hit: got stall=%0d data=%h expected 0/a5000080", stalls, rdata);
        end
`ifdef DCACHE_STATS_EN
        vectors++;
        if (hit_cnt_o !== 32'd7 || miss_cnt_o !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL counters_after_drop: got hit=%0d miss=%0d expected 7/3", hit_cnt_o, miss_cnt_o);
        end
`endif
    endtask

    task automatic test_reset_in_writeback();
        int          stalls;
        int          wb_before;
        bit          seen;
        logic [31:0] rdata;
        do_access(1'b1, 32'h0000_0444, 32'h1234_5678, 4, 0, stalls, rdata);
        wb_before = wb_count;
        seen      = 0;
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0844;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (mem_enable_o && mem_write_o) seen = 1;
            else @(negedge clk_i);
        end
        vectors++;
        if (!seen || mem_addr_o !== 32'h440) begin
            miscompares++;
            $display("[TB] FAIL wb_entry: got seen=%0d addr=%h expected 1/00000440", seen, mem_addr_o);
        end
        rst_i = 1'b0;
        #1;
        vectors++;
        if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: got en=%b we=%b expected 0/0", mem_enable_o, mem_write_o);
        end
`ifdef DCACHE_STATS_EN
        vectors++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL counters_cleared: got hit=%0d miss=%0d expected 0/0", hit_cnt_o, miss_cnt_o);
        end
`endif
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        #1;
        rst_i = 1'b1;
        do_access(1'b0, 32'h0000_0444, 32'h0, 4, 0, stalls, rdata);
        vectors++;
        if (stalls !== 6 || wb_count !== wb_before) begin
            miscompares++;
            $display("[TB] FAIL post_reset_miss: got stall=%0d wbs=%0d expected 6/%0d", stalls, wb_count, wb_before);
        end
        vectors++;
        if (last_rd_addr !== 32'h440 || rdata !== 32'hA500_0444) begin
            miscompares++;
            $display("[TB] FAIL post_reset_refill: got addr=%h data=%h expected 00000440/a5000444", last_rd_addr, rdata);
        end
`ifdef DCACHE_STATS_EN
        vectors++;
        if (hit_cnt_o !== 32'd1 || miss_cnt_o !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL counters_post_reset: got hit=%0d miss=%0d expected 1/1", hit_cnt_o, miss_cnt_o);
        end
`endif
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        wb_count     = 0;
        rd_count     = 0;
        last_wb_addr = '0;
        last_wb_data = '0;
        last_rd_addr = '0;
        $display("[TB] starting dcache_ctrl directed tests");
        test_reset();
        test_clean_miss();
        test_hit_store();
        test_dirty_miss();
        test_spurious_ack();
        test_req_drop();
        test_reset_in_writeback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
